// File: rtl/uart_disp_pkg.sv
// +----------------------------------------------------------------------+
// | Package : uart_disp_pkg                                              |
// | Purpose : Shared scan-state encoding and control-character codes for |
// |           the UART display scheduler.                                |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package uart_disp_pkg;

  // Display scan states
  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_e;

  localparam logic [7:0] CHR_CR = 8'h0D;  // clears the display
  localparam logic [7:0] CHR_BS = 8'h08;  // backspace (when enabled)

endpackage

`default_nettype wire

// File: rtl/disp_slot_timer.sv
// +----------------------------------------------------------------------+
// | Module  : disp_slot_timer                                            |
// | Purpose : Loadable down-counter. oDone is high while the count is 0; |
// |           the owner reloads it in the same cycle it acts on oDone,   |
// |           so oDone is a one-cycle pulse per period.                  |
// | Revision: 1.0 - initial release                                      |
// | Ports   : clk       in  system clock                                 |
// |           iRst      in  asynchronous active-low reset                |
// |           iLoad     in  load iLoadVal this cycle                     |
// |           iLoadVal  in  WIDTH  reload value (period - 1)             |
// |           oDone     out count has reached zero                       |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module disp_slot_timer #(
  parameter int              WIDTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             iRst,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iLoadVal,
  output logic             oDone
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge iRst) begin
    if (!iRst) begin
      cnt_q <= RST_VAL;
    end else if (iLoad) begin
      cnt_q <= iLoadVal;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign oDone = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/uart_display_scheduler.sv
// +----------------------------------------------------------------------+
// | Module  : uart_display_scheduler                                     |
// | Purpose : Scrolling character store fed by a UART RX byte stream,    |
// |           time-multiplexed through one registered ASCII-to-7seg      |
// |           decoder onto a common-anode display.                       |
// | Revision: 1.0 - initial release                                      |
// | Macro   : BACKSPACE_EN - 8'h08 deletes the newest character instead  |
// |           of being stored.                                           |
// | Ports   : clk        in  system clock                                |
// |           iRst       in  asynchronous active-low reset               |
// |           iData      in  8   received byte                           |
// |           iValid     in  1-cycle strobe qualifying iData             |
// |           oDecData   out 8   character to the decoder                |
// |           oDecValid  out 1-cycle decoder load strobe                 |
// |           oAn        out NUM_DIGITS anode enables, active low        |
// |           oCount     out number of occupied digits                   |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module uart_display_scheduler
  import uart_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                            clk,
  input  logic                            iRst,
  input  logic [7:0]                      iData,
  input  logic                            iValid,
  output logic [7:0]                      oDecData,
  output logic                            oDecValid,
  output logic [NUM_DIGITS-1:0]           oAn,
  output logic [$clog2(NUM_DIGITS+1)-1:0] oCount
);

  localparam int TMAX = (SLOT_CYCLES > BLANK_CYCLES) ? SLOT_CYCLES : BLANK_CYCLES;
  localparam int TW   = $clog2(TMAX);
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int CW   = $clog2(NUM_DIGITS + 1);

  localparam logic [TW-1:0] C_SLOT_LOAD  = TW'(SLOT_CYCLES - 1);
  localparam logic [TW-1:0] C_BLANK_LOAD = TW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] C_FULL       = CW'(NUM_DIGITS);
  localparam logic [IW-1:0] C_LAST_IDX   = IW'(NUM_DIGITS - 1);

  // ---------------- character store ----------------
  logic [NUM_DIGITS-1:0][7:0] char_q, char_d;
  logic [NUM_DIGITS-1:0]      occ_q,  occ_d;
  logic [CW-1:0]              count_q, count_d;

  always_comb begin
    char_d  = char_q;
    occ_d   = occ_q;
    count_d = count_q;
    if (iValid) begin
      if (iData == CHR_CR) begin
        occ_d   = '0;
        count_d = '0;
      end
`ifdef BACKSPACE_EN
      else if (iData == CHR_BS) begin
        // Shift toward digit 0; the top character is kept but marked empty.
        char_d  = {char_q[NUM_DIGITS-1], char_q[NUM_DIGITS-1:1]};
        occ_d   = {1'b0, occ_q[NUM_DIGITS-1:1]};
        if (count_q != '0) count_d = count_q - 1'b1;
      end
`endif
      else begin
        // Scroll left: oldest character falls off the top.
        char_d = {char_q[NUM_DIGITS-2:0], iData};
        occ_d  = {occ_q[NUM_DIGITS-2:0], 1'b1};
        if (count_q != C_FULL) count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge iRst) begin
    if (!iRst) begin
      char_q  <= '0;
      occ_q   <= '0;
      count_q <= '0;
    end else begin
      char_q  <= char_d;
      occ_q   <= occ_d;
      count_q <= count_d;
    end
  end

  // ---------------- scan FSM ----------------
  scan_state_e   state_q;
  logic [IW-1:0] idx_q;
  logic [7:0]    dec_data_q;
  logic          dec_valid_q;
  logic          tmr_done;
  logic          tmr_load;
  logic [TW-1:0] tmr_load_val;

  // SHOW is timed from its entry (loaded during LOAD); BLANK is timed from
  // the SHOW->BLANK transition. Reset value gives a full first BLANK.
  assign tmr_load     = (state_q == ST_LOAD) || ((state_q == ST_SHOW) && tmr_done);
  assign tmr_load_val = (state_q == ST_LOAD) ? C_SLOT_LOAD : C_BLANK_LOAD;

  disp_slot_timer #(
    .WIDTH   (TW),
    .RST_VAL (C_BLANK_LOAD)
  ) u_timer (
    .clk      (clk),
    .iRst     (iRst),
    .iLoad    (tmr_load),
    .iLoadVal (tmr_load_val),
    .oDone    (tmr_done)
  );

  // Decoder data/strobe are registered on entry to LOAD so they are visible
  // during the LOAD cycle; the decoder's own register then lines up with the
  // anode turning on in the first SHOW cycle.
  always_ff @(posedge clk or negedge iRst) begin
    if (!iRst) begin
      state_q     <= ST_BLANK;
      idx_q       <= '0;
      dec_data_q  <= '0;
      dec_valid_q <= 1'b0;
    end else begin
      dec_valid_q <= 1'b0;
      case (state_q)
        ST_BLANK: begin
          if (tmr_done) begin
            state_q     <= ST_LOAD;
            dec_data_q  <= char_q[idx_q];
            dec_valid_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          state_q <= ST_SHOW;
        end
        ST_SHOW: begin
          if (tmr_done) begin
            state_q <= ST_BLANK;
            idx_q   <= (idx_q == C_LAST_IDX) ? '0 : idx_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_BLANK;
        end
      endcase
    end
  end

  // Anode follows the live occupancy so a clear darkens the digit at once.
  always_comb begin
    oAn = '1;
    if ((state_q == ST_SHOW) && occ_q[idx_q]) oAn[idx_q] = 1'b0;
  end

  assign oDecData  = dec_data_q;
  assign oDecValid = dec_valid_q;
  assign oCount    = count_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_display_scheduler.sv
`timescale 1ns/1ps

module tb_uart_display_scheduler;

  localparam int ND  = 4;
  localparam int SC  = 8;
  localparam int BC  = 2;
  localparam int PER = SC + BC + 1;   // 11 cycles per slot

  logic       clk = 1'b0;
  logic       iRst = 1'b0;
  logic [7:0] iData = 8'h00;
  logic       iValid = 1'b0;
  logic [7:0] oDecData;
  logic       oDecValid;
  logic [3:0] oAn;
  logic [2:0] oCount;

  always #5 clk = ~clk;

  uart_display_scheduler #(
    .NUM_DIGITS   (ND),
    .SLOT_CYCLES  (SC),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk       (clk),
    .iRst      (iRst),
    .iData     (iData),
    .iValid    (iValid),
    .oDecData  (oDecData),
    .oDecValid (oDecValid),
    .oAn       (oAn),
    .oCount    (oCount)
  );

  int total = 0;
  int bad   = 0;
  bit run   = 1'b0;
  int cyc   = 0;   // cycles since reset release; phase = cyc % PER

  logic [7:0] m_chr [ND];
  bit         m_occ [ND];
  int         m_cnt = 0;

  typedef struct {int cyc; logic [7:0] data;} exp_t;
  exp_t sbq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_write(input logic [7:0] b);
    if (b == 8'h0D) begin
      for (int i = 0; i < ND; i++) m_occ[i] = 1'b0;
      m_cnt = 0;
    end
`ifdef BACKSPACE_EN
    else if (b == 8'h08) begin
      for (int i = 0; i < ND-1; i++) begin
        m_chr[i] = m_chr[i+1];
        m_occ[i] = m_occ[i+1];
      end
      m_occ[ND-1] = 1'b0;
      if (m_cnt > 0) m_cnt--;
    end
`endif
    else begin
      for (int i = ND-1; i > 0; i--) begin
        m_chr[i] = m_chr[i-1];
        m_occ[i] = m_occ[i-1];
      end
      m_chr[0] = b;
      m_occ[0] = 1'b1;
      if (m_cnt < ND) m_cnt++;
    end
  endfunction

  initial begin
    for (int i = 0; i < ND; i++) begin
      m_chr[i] = 8'h00;
      m_occ[i] = 1'b0;
    end
  end

  // Predictor: on the edge that enters LOAD, the decoder gets the store
  // contents as they were before any write on that same edge.
  always @(posedge clk) begin
    if (run) begin
      if (cyc % PER == BC - 1)
        sbq.push_back('{cyc + 1, m_chr[(cyc / PER) % ND]});
      if (iValid) model_write(iData);
      cyc++;
    end
  end

  // Monitor: anode/count every cycle, pop scoreboard on each decoder strobe.
  always @(negedge clk) begin
    if (run) begin
      int ph;
      int ix;
      logic [3:0] ea;
      exp_t e;
      ph = cyc % PER;
      ix = (cyc / PER) % ND;
      ea = 4'hF;
      if (ph > BC && m_occ[ix]) ea[ix] = 1'b0;
      check("anode", oAn, ea);
      check("count", oCount, m_cnt);
      if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL dec_valid_missing: no strobe at cyc %0d", sbq[0].cyc);
        void'(sbq.pop_front());
      end
      if (oDecValid) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL dec_valid_extra: strobe at cyc %0d, none expected", cyc);
        end else begin
          e = sbq.pop_front();
          check("load_cycle", cyc, e.cyc);
          check("dec_data", oDecData, e.data);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    iValid = 1'b1;
    iData  = b;
    @(negedge clk);
    iValid = 1'b0;
  endtask

  // Returns at the negedge inside the requested slot index / phase.
  task automatic wait_slot(input int ix, input int ph);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (cyc % PER == ph && (cyc / PER) % ND == ix) return;
    end
    total++;
    bad++;
    $display("FAIL wait_slot: idx %0d phase %0d not reached", ix, ph);
  endtask

  initial begin
    iRst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_an", oAn, 4'hF);
    check("rst_dec_valid", oDecValid, 1'b0);
    check("rst_dec_data", oDecData, 8'h00);
    check("rst_count", oCount, 3'd0);
    iRst = 1'b1;
    run  = 1'b1;

    // idle: display dark, strobe every PER cycles (checked by monitor)
    repeat (100) @(negedge clk);

    send(8'h31); send(8'h32); send(8'h33); send(8'h34);
    check("count_after_4", oCount, 3'd4);
    wait_slot(0, BC);     check("idx0_char", oDecData, 8'h34);
    wait_slot(0, BC + 3); check("idx0_an", oAn, 4'b1110);
    wait_slot(3, BC);     check("idx3_char", oDecData, 8'h31);
    wait_slot(3, BC + 3); check("idx3_an", oAn, 4'b0111);

    send(8'h35);
    check("count_sat", oCount, 3'd4);
    wait_slot(3, BC);     check("idx3_scrolled", oDecData, 8'h32);
    wait_slot(0, BC);     check("idx0_new", oDecData, 8'h35);

    send(8'h0D);
    check("count_cr", oCount, 3'd0);
    repeat (2 * PER) @(negedge clk);
    wait_slot(1, BC + 3); check("an_after_cr", oAn, 4'hF);

    // write during LOAD of idx0: this slot shows the old char
    wait_slot(0, BC);
    check("load_old", oDecData, 8'h35);
    send(8'h37);
    wait_slot(0, BC);     check("load_next", oDecData, 8'h37);

`ifdef BACKSPACE_EN
    send(8'h0D);
    send(8'h31); send(8'h32); send(8'h08);
    check("bs_count1", oCount, 3'd1);
    wait_slot(0, BC);     check("bs_idx0", oDecData, 8'h31);
    send(8'h08); send(8'h08); send(8'h08);
    check("bs_count0", oCount, 3'd0);
`endif

    // asynchronous reset in the middle of a lit SHOW
    send(8'h41);
    wait_slot(0, BC + 3);
    check("pre_reset_an", oAn, 4'b1110);
    check("sb_empty", sbq.size(), 0);
    run  = 1'b0;
    iRst = 1'b0;
    #1;
    check("async_rst_an", oAn, 4'hF);
    check("async_rst_count", oCount, 3'd0);
    check("async_rst_valid", oDecValid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
